// File: rtl/alu_core_pkg.sv
// Shared types for the ALU command responder: opcode and FSM encodings plus default widths.
package alu_core_pkg;

    localparam int unsigned AluWidth    = 8;
    localparam int unsigned AluResWidth = 2 * AluWidth;

    // Opcode encodings are fixed by the command interface.
    typedef enum logic [2:0] {
        NoOp      = 3'd0,
        AddOp     = 3'd1,
        AndOp     = 3'd2,
        XorOp     = 3'd3,
        MulOp     = 3'd4,
        Unused5Op = 3'd5,
        Unused6Op = 3'd6,
        RstOp     = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StExec    = 2'd1,
        StMul     = 2'd2,
        StWaitLow = 2'd3
    } alu_state_t;

    // Single-cycle operations that complete in the EXEC state.
    function automatic logic is_single_cycle_op(operation_t o);
        return (o == AddOp) || (o == AndOp) || (o == XorOp);
    endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle, LSB of b first.
// valid/product are combinational in the final iteration cycle so the caller can capture
// the full product on the same edge that retires the last iteration.
module alu_shift_add_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [CntW-1:0]    cnt_q;

    // Accumulator value after the current iteration.
    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    assign busy    = (cnt_q != '0);
    assign valid   = busy && (cnt_q == CntW'(1));
    assign product = acc_next;

    // Operand/accumulator registers: load, abort, or step one iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CntW'(WIDTH);
        end else if (abort) begin
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (busy) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/alu_core.sv
// ALU start/done command responder: add/and/xor in one cycle, mul via iterative multiplier.
// Optional macro ALU_ILLEGAL_OP_ERR_EN adds an err output that flags opcodes 5/6.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int unsigned WIDTH = AluWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    input  logic               start,
    output logic               done,
    output logic [2*WIDTH-1:0] result
`ifdef ALU_ILLEGAL_OP_ERR_EN
    ,
    output logic               err
`endif
);

    alu_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    operation_t         op_q;
    logic               accept;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     sum;

    logic               mul_load, mul_abort, mul_busy, mul_valid;
    logic [2*WIDTH-1:0] mul_product;

`ifdef ALU_ILLEGAL_OP_ERR_EN
    logic err_q, err_d;
`endif

    operation_t op_in;
    assign op_in = operation_t'(op);
    assign sum   = {1'b0, a_q} + {1'b0, b_q};

    alu_shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .abort   (mul_abort),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .valid   (mul_valid),
        .product (mul_product)
    );

    // Next-state, result and done decode.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        mul_load  = 1'b0;
        mul_abort = 1'b0;
        result_d  = result_q;
        done_d    = 1'b0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
        err_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_single_cycle_op(op_in)) begin
                        accept  = 1'b1;
                        state_d = StExec;
                    end else if (op_in == MulOp) begin
                        mul_load = 1'b1;
                        state_d  = StMul;
`ifdef ALU_ILLEGAL_OP_ERR_EN
                    end else if (op_in == Unused5Op || op_in == Unused6Op) begin
                        accept  = 1'b1;
                        state_d = StExec;
`endif
                    end else begin
                        state_d = StWaitLow;
                    end
                end
            end
            StExec: begin
                if (!start) begin
                    state_d = StIdle;
                end else begin
                    done_d  = 1'b1;
                    state_d = StWaitLow;
                    unique case (op_q)
                        AddOp:   result_d = {{(WIDTH-1){1'b0}}, sum};
                        AndOp:   result_d = {{WIDTH{1'b0}}, a_q & b_q};
                        XorOp:   result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
                        default: begin
                            // Only illegal opcodes reach here; they report a zero result.
                            result_d = '0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
                            err_d    = 1'b1;
`endif
                        end
                    endcase
                end
            end
            StMul: begin
                if (!start) begin
                    mul_abort = 1'b1;
                    state_d   = StIdle;
                end else if (mul_valid) begin
                    result_d = mul_product;
                    done_d   = 1'b1;
                    state_d  = StWaitLow;
                end else if (!mul_busy) begin
                    // Multiplier idle without completing: recover rather than hang.
                    state_d = StIdle;
                end
            end
            StWaitLow: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= NoOp;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef ALU_ILLEGAL_OP_ERR_EN
            err_q    <= err_d;
`endif
            if (accept) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op_in;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
`ifdef ALU_ILLEGAL_OP_ERR_EN
    assign err    = err_q;
`endif

endmodule
